// File: rtl/pipeline_sequencer_pkg.sv
// Shared types and default frame geometry for the image pipeline sequencer.
// Derived widths here follow the default geometry; the top derives its own from its parameters.
package pipeline_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        FLUSH
    } state_t;

    localparam int FRAME_WIDTH  = 640;
    localparam int FRAME_HEIGHT = 480;
    localparam int PIXEL_SIZE   = 24;
    localparam int CENTER_DELAY = FRAME_WIDTH + 2;

    localparam int X_W = $clog2(FRAME_WIDTH);
    localparam int Y_W = $clog2(FRAME_HEIGHT);
    localparam int C_W = $clog2(FRAME_WIDTH * FRAME_HEIGHT + CENTER_DELAY);

endpackage

// File: rtl/pipeline_sequencer_pos_counter.sv
// Row-major x/y position counter: advances on step, wraps x at WIDTH and y at HEIGHT,
// and flags when each coordinate sits on its last value.
module pos_counter #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    localparam int XW = $clog2(WIDTH),
    localparam int YW = $clog2(HEIGHT)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          step,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          x_last,
    output logic          y_last
);

    assign x_last = (x == XW'(WIDTH - 1));
    assign y_last = (y == YW'(HEIGHT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x <= '0;
            y <= '0;
        end else if (step) begin
            if (x_last) begin
                x <= '0;
                y <= y_last ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipeline_sequencer.sv
// Frame sequencer: feeds a source pixel stream into the image pipeline, flushes its row
// buffers after each frame and tags the pipeline output with window-centre coordinates.
module pipeline_sequencer #(
    parameter int FRAME_WIDTH  = pipeline_sequencer_pkg::FRAME_WIDTH,
    parameter int FRAME_HEIGHT = pipeline_sequencer_pkg::FRAME_HEIGHT,
    parameter int CENTER_DELAY = FRAME_WIDTH + 2,
    parameter int PIXEL_SIZE   = pipeline_sequencer_pkg::PIXEL_SIZE,
    localparam int XW = $clog2(FRAME_WIDTH),
    localparam int YW = $clog2(FRAME_HEIGHT)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
    input  logic                  src_valid,
    output logic                  src_ready,
    input  logic [PIXEL_SIZE-1:0] src_data,
    output logic                  pipe_en,
    output logic                  pipe_hsync,
    output logic                  pipe_vsync,
    output logic [PIXEL_SIZE-1:0] pipe_data,
    input  logic [PIXEL_SIZE-1:0] pipe_out,
    output logic                  dst_valid,
    input  logic                  dst_ready,
    output logic [PIXEL_SIZE-1:0] dst_data,
    output logic [XW-1:0]         dst_x,
    output logic [YW-1:0]         dst_y,
    output logic                  dst_sof,
    output logic                  dst_eof,
    output logic                  dst_border,
    output logic                  busy,
    output logic                  frame_done
);
    import pipeline_sequencer_pkg::state_t;
    import pipeline_sequencer_pkg::IDLE;
    import pipeline_sequencer_pkg::ACTIVE;
    import pipeline_sequencer_pkg::FLUSH;

    localparam int CW = $clog2(FRAME_WIDTH * FRAME_HEIGHT + CENTER_DELAY);
    localparam logic [CW-1:0] C_CENTER = CW'(CENTER_DELAY);
    localparam logic [CW-1:0] C_LAST   = CW'(FRAME_WIDTH * FRAME_HEIGHT + CENTER_DELAY - 1);

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] c;
    logic          accept;
    logic          last_en;
    logic [XW-1:0] in_x;
    logic [YW-1:0] in_y;
    logic          in_x_last;
    logic          in_y_last;
    logic          out_x_last;
    logic          out_y_last;
    logic          unused_in_pos;

    // Input coordinates only matter through their last-value flags.
    assign unused_in_pos = ^{in_x, in_y};
    assign accept        = src_valid & src_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (run) state_next = ACTIVE;
            ACTIVE:  if (accept & in_x_last & in_y_last) state_next = FLUSH;
            FLUSH:   if (last_en) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state != IDLE);
        src_ready  = dst_ready & (state == ACTIVE);
        pipe_en    = dst_ready & (((state == ACTIVE) & src_valid) | (state == FLUSH));
        pipe_data  = (state == ACTIVE) ? src_data : '0;
        // The last real pixel carries no hsync; vsync marks the final flush enable instead.
        pipe_hsync = pipe_en & (state == ACTIVE) & in_x_last & ~in_y_last;
        last_en    = pipe_en & (state == FLUSH) & (c == C_LAST);
        pipe_vsync = last_en;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            c          <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= last_en;
            if (last_en) begin
                c <= '0;
            end else if (pipe_en) begin
                c <= c + 1'b1;
            end
        end
    end

    // The first CENTER_DELAY enables only fill the window; their results are stale.
    assign dst_valid  = pipe_en & (c >= C_CENTER);
    assign dst_sof    = dst_valid & (c == C_CENTER);
    assign dst_eof    = dst_valid & (c == C_LAST);
    assign dst_border = dst_valid & ((dst_x == '0) | out_x_last | (dst_y == '0) | out_y_last);
    assign dst_data   = pipe_out;

    pos_counter #(
        .WIDTH (FRAME_WIDTH),
        .HEIGHT(FRAME_HEIGHT)
    ) u_in_pos (
        .clk   (clk),
        .reset (reset),
        .step  (accept),
        .x     (in_x),
        .y     (in_y),
        .x_last(in_x_last),
        .y_last(in_y_last)
    );

    pos_counter #(
        .WIDTH (FRAME_WIDTH),
        .HEIGHT(FRAME_HEIGHT)
    ) u_out_pos (
        .clk   (clk),
        .reset (reset),
        .step  (dst_valid),
        .x     (dst_x),
        .y     (dst_y),
        .x_last(out_x_last),
        .y_last(out_y_last)
    );

endmodule
